// File: rtl/nfu_zero_elim_pkg.sv
// Shared types and sizes for the NFU-1A zero-elimination scheduler and mux stage.
// A slot holds one brick plus its per-lane consumed bits and window-last flag.
package nfu_zero_elim_pkg;

    localparam int unsigned BIT_WIDTH = 16;
    localparam int unsigned Tn        = 16;
    localparam int unsigned TnxTn     = Tn * Tn;
    localparam int unsigned SEL_WIDTH = 1;
    localparam int unsigned CNT_WIDTH = 16;

    typedef logic [Tn-1:0][BIT_WIDTH-1:0] brick_t;

    typedef struct packed {
        logic          valid;
        brick_t        data;
        logic [Tn-1:0] cons;
        logic          last;
    } slot_t;

    function automatic logic [Tn-1:0] live_mask(input slot_t s);
        logic [Tn-1:0] m;
        m = '0;
        for (int i = 0; i < Tn; i++) begin
            m[i] = (s.data[i] != '0) && !s.cons[i];
        end
        return m;
    endfunction

    // A brick with nothing left to contribute is dropped unless it closes the window.
    function automatic logic slot_dead(input slot_t s);
        return (live_mask(s) == '0) && !s.last;
    endfunction

endpackage

// File: rtl/nfu_1a_lane_sel.sv
// One lane of the scheduler: decides whether the lookahead value replaces a
// zero (or consumed) current value, and whether the lane yields an operand.
module nfu_1a_lane_sel
    import nfu_zero_elim_pkg::*;
(
    input  logic [BIT_WIDTH-1:0] i_cur_data,
    input  logic                 i_cur_cons,
    input  logic [BIT_WIDTH-1:0] i_la_data,
    input  logic                 i_la_cons,
    input  logic                 i_lau,
    output logic                 o_sel,
    output logic                 o_mask
);

    logic w_cur_live;
    logic w_la_live;

    assign w_cur_live = (i_cur_data != '0) && !i_cur_cons;
    assign w_la_live  = (i_la_data != '0) && !i_la_cons;
    assign o_sel      = !w_cur_live && i_lau && w_la_live;
    assign o_mask     = w_cur_live || o_sel;

endmodule

// File: rtl/nfu_1a_sched_d1_w0.sv
// Two-slot (current + lookahead) brick scheduler feeding the D=1/W=0 NFU-1A muxes.
// Fills current-brick zeros from the same lane of the lookahead and drops dead bricks.
module nfu_1a_sched_d1_w0
    import nfu_zero_elim_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [BIT_WIDTH*Tn-1:0]    i_in_brick,
    input  logic                       i_in_last,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [BIT_WIDTH*Tn-1:0]    o_cur_inputs,
    output logic [BIT_WIDTH*Tn-1:0]    o_repl_cands,
    output logic [SEL_WIDTH*TnxTn-1:0] o_sel_lines,
    output logic [Tn-1:0]              o_lane_mask,
    output logic                       o_last,
    output logic [CNT_WIDTH-1:0]       o_skip_count
);

    slot_t                r_cur;
    slot_t                r_la;
    logic [CNT_WIDTH-1:0] r_skip;

    slot_t                w_cur_nxt;
    slot_t                w_la_nxt;
    slot_t                w_la_upd;
    slot_t                w_in_slot;
    logic [1:0]           w_skip_inc;
    logic [CNT_WIDTH:0]   w_skip_sum;
    logic [CNT_WIDTH-1:0] w_skip_nxt;
    logic [Tn-1:0]        w_sel;
    logic [Tn-1:0]        w_mask;
    logic                 w_lau;
    logic                 w_fire;
    logic                 w_acc;

    assign w_lau       = r_la.valid && !r_cur.last;
    assign o_out_valid = r_cur.valid && (r_la.valid || r_cur.last);
    assign w_fire      = o_out_valid && i_out_ready;
    assign o_in_ready  = !r_la.valid || w_fire;
    assign w_acc       = i_in_valid && o_in_ready;
    assign w_in_slot   = '{valid: 1'b1, data: i_in_brick, cons: '0, last: i_in_last};

    for (genvar gi = 0; gi < Tn; gi++) begin : g_lane
        nfu_1a_lane_sel u_lane_sel (
            .i_cur_data (r_cur.data[gi]),
            .i_cur_cons (r_cur.cons[gi]),
            .i_la_data  (r_la.data[gi]),
            .i_la_cons  (r_la.cons[gi]),
            .i_lau      (w_lau),
            .o_sel      (w_sel[gi]),
            .o_mask     (w_mask[gi])
        );

        assign o_cur_inputs[gi*BIT_WIDTH +: BIT_WIDTH] = r_cur.cons[gi] ? '0 : r_cur.data[gi];
        assign o_repl_cands[gi*BIT_WIDTH +: BIT_WIDTH] = w_lau ? r_la.data[gi] : '0;

        // Select is broadcast along the row: every mux (i, j) follows lane i.
        for (genvar gj = 0; gj < Tn; gj++) begin : g_sel_col
            assign o_sel_lines[(gi*Tn+gj)*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(w_sel[gi]);
        end
    end

    assign o_lane_mask  = w_mask;
    assign o_last       = r_cur.last;
    assign o_skip_count = r_skip;

    always_comb begin
        w_la_upd      = r_la;
        w_la_upd.cons = r_la.cons | w_sel;
    end

    always_comb begin
        w_cur_nxt  = r_cur;
        w_la_nxt   = r_la;
        w_skip_inc = 2'd0;
        if (!r_cur.valid) begin
            if (w_acc) begin
                if (slot_dead(w_in_slot)) begin
                    w_skip_inc = w_skip_inc + 2'd1;
                end else begin
                    w_cur_nxt = w_in_slot;
                end
            end
        end else if (w_fire) begin
            w_cur_nxt = '0;
            w_la_nxt  = '0;
            if (r_la.valid && !slot_dead(w_la_upd)) begin
                w_cur_nxt = w_la_upd;
                if (w_acc) begin
                    w_la_nxt = w_in_slot;
                end
            end else begin
                if (r_la.valid) begin
                    w_skip_inc = w_skip_inc + 2'd1;
                end
                // With the lookahead gone, the incoming brick heads straight for CUR.
                if (w_acc) begin
                    if (slot_dead(w_in_slot)) begin
                        w_skip_inc = w_skip_inc + 2'd1;
                    end else begin
                        w_cur_nxt = w_in_slot;
                    end
                end
            end
        end else if (w_acc) begin
            w_la_nxt = w_in_slot;
        end
    end

    assign w_skip_sum = {1'b0, r_skip} + (CNT_WIDTH+1)'(w_skip_inc);
    assign w_skip_nxt = w_skip_sum[CNT_WIDTH] ? '1 : w_skip_sum[CNT_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur  <= '0;
            r_la   <= '0;
            r_skip <= '0;
        end else begin
            r_cur  <= w_cur_nxt;
            r_la   <= w_la_nxt;
            r_skip <= w_skip_nxt;
        end
    end

endmodule

// File: tb/tb_nfu_1a_sched_d1_w0.sv
// Bench for the NFU-1A scheduler: directed scenarios plus a random stream checked
// against a queue-of-bricks reference model.
module tb_nfu_1a_sched_d1_w0;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [255:0] i_in_brick;
    logic         i_in_last;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [255:0] o_cur_inputs;
    logic [255:0] o_repl_cands;
    logic [255:0] o_sel_lines;
    logic [15:0]  o_lane_mask;
    logic         o_last;
    logic [15:0]  o_skip_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [255:0] data;
        logic [15:0]  cons;
        logic         last;
    } mbrick_t;

    mbrick_t     q[$];
    int unsigned m_skip;

    nfu_1a_sched_d1_w0 dut (
        .clk          (clk),
        .rst          (rst),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_in_brick   (i_in_brick),
        .i_in_last    (i_in_last),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_cur_inputs (o_cur_inputs),
        .o_repl_cands (o_repl_cands),
        .o_sel_lines  (o_sel_lines),
        .o_lane_mask  (o_lane_mask),
        .o_last       (o_last),
        .o_skip_count (o_skip_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_in_valid  = 1'b0;
        i_in_brick  = '0;
        i_in_last   = 1'b0;
        i_out_ready = 1'b0;
        rst         = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [255:0] seq_brick(input int k);
        logic [255:0] b;
        for (int i = 0; i < 16; i++) b[i*16 +: 16] = 16'(k*16 + i + 1);
        return b;
    endfunction

    function automatic logic [255:0] sel_rows(input logic [15:0] sel);
        logic [255:0] s;
        for (int i = 0; i < 16; i++) s[i*16 +: 16] = sel[i] ? 16'hFFFF : 16'h0000;
        return s;
    endfunction

    function automatic bit is_dead(input mbrick_t b);
        for (int i = 0; i < 16; i++) begin
            if (b.data[i*16 +: 16] != 16'd0 && !b.cons[i]) return 1'b0;
        end
        return !b.last;
    endfunction

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_skip_count !== 16'd0 ||
            o_lane_mask !== 16'd0 || o_last !== 1'b0 || o_cur_inputs !== 256'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ready=%b skip=%0d mask=%h last=%b want 0 1 0 0 0",
                     o_out_valid, o_in_ready, o_skip_count, o_lane_mask, o_last);
        end
        tick();
        // One dead brick first so the skip count is nonzero before the mid-stream reset.
        i_in_valid = 1'b1; i_in_brick = '0; i_in_last = 1'b0;
        tick();
        i_in_brick = seq_brick(0);
        tick();
        i_in_brick = seq_brick(1);
        tick();
        i_in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_out_valid !== 1'b1 || o_skip_count !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_prefill: valid=%b skip=%0d want 1 1", o_out_valid, o_skip_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_skip_count !== 16'd0 ||
            o_cur_inputs !== 256'd0) begin
            n_fail++;
            $display("FAIL reset_midstream: valid=%b ready=%b skip=%0d want 0 1 0",
                     o_out_valid, o_in_ready, o_skip_count);
        end
        tick();
        i_in_valid = 1'b1; i_in_brick = seq_brick(2); i_in_last = 1'b1;
        tick();
        i_in_valid = 1'b0; i_in_last = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_out_valid !== 1'b1 || o_cur_inputs !== seq_brick(2) || o_last !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_restream: valid=%b last=%b cur=%h want 1 1 %h",
                     o_out_valid, o_last, o_cur_inputs, seq_brick(2));
        end
    endtask

    task automatic test_lane_fill();
        logic [255:0] b0;
        logic [255:0] b1;
        logic [255:0] b1_out;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            b0[i*16 +: 16] = (i == 0 || i == 2) ? 16'd0 : (i == 1) ? 16'd5 :
                             (i == 3) ? 16'd7 : 16'(16'h100 + i);
            b1[i*16 +: 16] = 16'd3;
        end
        b1_out = b1;
        b1_out[0 +: 16]  = 16'd0;
        b1_out[32 +: 16] = 16'd0;
        i_in_valid = 1'b1; i_in_brick = b0; i_in_last = 1'b0;
        tick();
        i_in_brick = b1; i_in_last = 1'b1;
        tick();
        i_in_valid = 1'b0; i_in_last = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_handshake: valid=%b ready=%b want 1 0", o_out_valid, o_in_ready);
        end
        n_checks++;
        if (o_sel_lines !== sel_rows(16'h0005) || o_lane_mask !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL fill_sel: sel=%h mask=%h want %h ffff",
                     o_sel_lines, o_lane_mask, sel_rows(16'h0005));
        end
        n_checks++;
        if (o_repl_cands !== b1 || o_cur_inputs !== b0 || o_last !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_data: repl=%h cur=%h last=%b", o_repl_cands, o_cur_inputs, o_last);
        end
        i_out_ready = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (o_out_valid !== 1'b1 || o_cur_inputs !== b1_out || o_last !== 1'b1 ||
            o_sel_lines !== 256'd0 || o_lane_mask !== 16'hFFFA || o_repl_cands !== 256'd0) begin
            n_fail++;
            $display("FAIL fill_second: valid=%b cur=%h last=%b mask=%h want cur=%h mask=fffa",
                     o_out_valid, o_cur_inputs, o_last, o_lane_mask, b1_out);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_drain: valid=%b ready=%b want 0 1", o_out_valid, o_in_ready);
        end
        i_out_ready = 1'b0;
    endtask

    task automatic test_drop();
        logic [255:0] b0;
        logic [255:0] b1;
        logic [255:0] b2;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            b0[i*16 +: 16] = (i == 4) ? 16'd0 : 16'(16'h200 + i);
            b1[i*16 +: 16] = (i == 4) ? 16'd9 : 16'd0;
            b2[i*16 +: 16] = 16'(16'h300 + i);
        end
        i_in_valid = 1'b1; i_in_brick = b0;
        tick();
        i_in_brick = b1;
        tick();
        i_in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_sel_lines !== sel_rows(16'h0010) || o_lane_mask !== 16'hFFFF ||
            o_repl_cands !== b1 || o_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_sel: sel=%h mask=%h valid=%b", o_sel_lines, o_lane_mask, o_out_valid);
        end
        i_in_valid = 1'b1; i_in_brick = b2; i_in_last = 1'b1; i_out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_ready_on_fire: ready=%b want 1", o_in_ready);
        end
        tick();
        i_in_valid = 1'b0; i_in_last = 1'b0; i_out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_skip_count !== 16'd1 || o_out_valid !== 1'b1 || o_cur_inputs !== b2 ||
            o_last !== 1'b1 || o_sel_lines !== 256'd0) begin
            n_fail++;
            $display("FAIL drop_next: skip=%0d valid=%b last=%b cur=%h want skip=1 cur=%h",
                     o_skip_count, o_out_valid, o_last, o_cur_inputs, b2);
        end
    endtask

    task automatic test_dead_last();
        do_reset();
        i_in_valid = 1'b1; i_in_brick = '0; i_in_last = 1'b1;
        tick();
        i_in_valid = 1'b0; i_in_last = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_out_valid !== 1'b1 || o_lane_mask !== 16'd0 || o_last !== 1'b1 ||
            o_skip_count !== 16'd0) begin
            n_fail++;
            $display("FAIL dead_last: valid=%b mask=%h last=%b skip=%0d want 1 0 1 0",
                     o_out_valid, o_lane_mask, o_last, o_skip_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_in_valid = 1'b1; i_in_brick = seq_brick(0);
        tick();
        i_in_brick = seq_brick(1);
        tick();
        i_in_brick = seq_brick(2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (o_in_ready !== 1'b0 || o_out_valid !== 1'b1 || o_cur_inputs !== seq_brick(0) ||
                o_repl_cands !== seq_brick(1)) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: ready=%b valid=%b cur=%h", c, o_in_ready,
                         o_out_valid, o_cur_inputs);
            end
            tick();
        end
        i_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_in_brick = seq_brick(k + 2);
            @(negedge clk);
            n_checks++;
            if (o_out_valid !== 1'b1 || o_in_ready !== 1'b1 || o_cur_inputs !== seq_brick(k)) begin
                n_fail++;
                $display("FAIL stream_emit%0d: valid=%b ready=%b cur=%h want %h", k, o_out_valid,
                         o_in_ready, o_cur_inputs, seq_brick(k));
            end
            tick();
        end
        i_in_valid = 1'b0; i_out_ready = 1'b0;
    endtask

    task automatic test_random();
        mbrick_t      nb;
        mbrick_t      tmp;
        logic [255:0] exp_cur;
        logic [255:0] exp_repl;
        logic [15:0]  exp_sel;
        logic [15:0]  exp_mask;
        bit           exp_valid;
        bit           exp_ready;
        bit           lau;
        bit           cl;
        bit           ll;
        int           n;
        do_reset();
        q.delete();
        m_skip = 0;
        for (int c = 0; c < 3000; c++) begin
            nb.cons = '0;
            nb.last = ($urandom % 6) == 0;
            if ($urandom % 6 == 0) begin
                nb.data = '0;
            end else begin
                for (int i = 0; i < 16; i++)
                    nb.data[i*16 +: 16] = ($urandom % 3 == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            end
            i_in_valid  = ($urandom % 4) != 0;
            i_in_brick  = nb.data;
            i_in_last   = nb.last;
            i_out_ready = ($urandom % 4) != 0;

            n         = q.size();
            exp_valid = (n >= 1) && ((n >= 2) || q[0].last);
            lau       = (n >= 2) && !q[0].last;
            exp_sel   = '0;
            exp_mask  = '0;
            exp_cur   = '0;
            exp_repl  = '0;
            if (n >= 1) begin
                for (int i = 0; i < 16; i++) begin
                    cl = q[0].data[i*16 +: 16] != 16'd0 && !q[0].cons[i];
                    ll = lau && q[1].data[i*16 +: 16] != 16'd0 && !q[1].cons[i];
                    exp_sel[i]  = !cl && ll;
                    exp_mask[i] = cl || exp_sel[i];
                    exp_cur[i*16 +: 16] = q[0].cons[i] ? 16'd0 : q[0].data[i*16 +: 16];
                end
                if (lau) exp_repl = q[1].data;
            end
            exp_ready = (n < 2) || (exp_valid && i_out_ready);

            @(negedge clk);
            n_checks++;
            if (o_out_valid !== exp_valid || o_in_ready !== exp_ready ||
                o_skip_count !== 16'(m_skip)) begin
                n_fail++;
                $display("FAIL rand_ctrl c=%0d: valid=%b ready=%b skip=%0d want %b %b %0d", c,
                         o_out_valid, o_in_ready, o_skip_count, exp_valid, exp_ready, m_skip);
            end
            if (exp_valid) begin
                n_checks++;
                if (o_cur_inputs !== exp_cur || o_repl_cands !== exp_repl ||
                    o_sel_lines !== sel_rows(exp_sel) || o_lane_mask !== exp_mask ||
                    o_last !== q[0].last) begin
                    n_fail++;
                    $display("FAIL rand_data c=%0d: mask=%h want %h last=%b sel=%h want %h", c,
                             o_lane_mask, exp_mask, o_last, o_sel_lines[15:0], exp_sel);
                end
            end

            // Model: the queue head is the current brick, the next entry the lookahead.
            if (exp_valid && i_out_ready) begin
                if (n >= 2) begin
                    tmp = q[1];
                    tmp.cons = tmp.cons | exp_sel;
                    q[1] = tmp;
                end
                void'(q.pop_front());
                if (q.size() >= 1 && is_dead(q[0])) begin
                    void'(q.pop_front());
                    if (m_skip < 65535) m_skip++;
                end
            end
            if (i_in_valid && exp_ready) begin
                q.push_back(nb);
                if (is_dead(q[0])) begin
                    void'(q.pop_front());
                    if (m_skip < 65535) m_skip++;
                end
            end
            tick();
        end
        i_in_valid = 1'b0; i_out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        i_in_valid = 1'b1; i_in_brick = '0; i_in_last = 1'b0;
        for (int n = 1; n <= 70000; n++) begin
            tick();
            if (n == 65534) begin
                n_checks++;
                if (o_skip_count !== 16'd65534) begin
                    n_fail++;
                    $display("FAIL skip_count_65534: got %0d want 65534", o_skip_count);
                end
            end
        end
        i_in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_skip_count !== 16'hFFFF || o_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL skip_saturate: skip=%0d valid=%b want 65535 0", o_skip_count, o_out_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_lane_fill();
        test_drop();
        test_dead_last();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
